// File: rtl/pe_accumulator.sv
// Output-stationary partial-sum accumulator for a PE column.
// Feeds the running sum back to the PE adder and emits one result per group.
module pe_accumulator #(
    parameter int ACC_W = 20,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic [LEN_W-1:0] acc_len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ACC_W-1:0] pe_sum,
    output logic [ACC_W-1:0] previous_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic [LEN_W-1:0] out_count
);

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] out_data_q, out_data_d;
    logic [LEN_W-1:0] out_count_q, out_count_d;

    logic             first;
    logic             last;
    logic [LEN_W-1:0] len_eff;
    logic [LEN_W-1:0] len_cur;
    logic [LEN_W-1:0] cnt_inc;

    // A zero length behaves like a length of one.
    assign len_eff = (acc_len == '0) ? LEN_W'(1) : acc_len;
    assign first   = (cnt_q == '0);
    assign len_cur = first ? len_eff : len_q;
    assign last    = (cnt_q == len_cur - LEN_W'(1));
    assign cnt_inc = cnt_q + LEN_W'(1);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        if (clear) begin
            state_d     = ACC;
            cnt_d       = '0;
            acc_d       = '0;
            out_count_d = '0;
        end else begin
            case (state_q)
                ACC: begin
                    if (in_valid) begin
                        if (first) begin
                            len_d = len_eff;
                        end
                        if (last) begin
                            out_data_d  = pe_sum;
                            out_count_d = cnt_inc;
                            cnt_d       = '0;
                            state_d     = HOLD;
                        end else begin
                            acc_d = pe_sum;
                            cnt_d = cnt_inc;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_d = ACC;
                    end
                end
                default: state_d = ACC;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACC;
            cnt_q       <= '0;
            len_q       <= '0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_count_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
        end
    end

    // Feedback is zero at a group start so the PE adds onto a clean sum.
    assign previous_sum = first ? '0 : acc_q;
    assign in_ready     = (state_q == ACC);
    assign out_valid    = (state_q == HOLD);
    assign out_data     = out_data_q;
    assign out_count    = out_count_q;

endmodule

// File: doc/pe_accumulator.md
PE_ACCUMULATOR -- requirements
Module: pe_accumulator

Interface
REQ-001 The block SHALL have parameter ACC_W, default 20, meaning the width of the partial-sum, feedback and result paths.
REQ-002 The block SHALL have parameter LEN_W, default 8, meaning the width of the group-length input and beat counter.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 Port clk  input  1  rising-edge clock for all state.
REQ-005 Port rst_n  input  1  asynchronous active-low reset.
REQ-006 Port clear  input  1  synchronous abort of the current group.
REQ-007 Port acc_len  input  LEN_W  number of PE_sum beats per output result; 0 is treated as 1.
REQ-008 Port in_valid  input  1  pe_sum holds a valid beat.
REQ-009 Port in_ready  output  1  block accepts a beat this cycle.
REQ-010 Port pe_sum  input  ACC_W  signed two's-complement sum from the PE adder stage, which already includes previous_sum.
REQ-011 Port previous_sum  output  ACC_W  signed feedback value driven into the PE adder stage.
REQ-012 Port out_valid  output  1  out_data holds a completed group result.
REQ-013 Port out_ready  input  1  downstream accepts out_data.
REQ-014 Port out_data  output  ACC_W  signed accumulated group result.
REQ-015 Port out_count  output  LEN_W  number of beats that formed out_data.

Function
REQ-016 The block SHALL implement two states: ACC (collecting beats) and HOLD (result presented).
REQ-017 in_ready SHALL be 1 in ACC and 0 in HOLD, purely from state.
REQ-018 A beat is accepted only when in_valid and in_ready are both 1 on a rising edge.
REQ-019 On the first beat of a group (cnt==0), the block SHALL latch acc_len into len_q, with 0 latched as 1; acc_len is ignored at all other times.
REQ-020 previous_sum SHALL be 0 when cnt==0 and SHALL equal the internal accumulator acc otherwise, combinationally from registers.
REQ-021 On each accepted non-final beat, acc SHALL load pe_sum unchanged (no re-add) and cnt SHALL increment by 1.
REQ-022 The final beat is the accepted beat with cnt == (latched or just-latched length) - 1.
REQ-023 On the final beat, out_data SHALL load pe_sum, out_count SHALL load cnt+1, cnt SHALL clear to 0, and the state SHALL go to HOLD.
REQ-024 out_valid SHALL be 1 exactly while in HOLD, so result latency is 1 cycle after the final beat is accepted.
REQ-025 In HOLD, out_data and out_count SHALL stay stable until out_valid and out_ready are both 1, then the state SHALL return to ACC.
REQ-026 With length 1, every accepted beat SHALL produce a result with previous_sum = 0 and out_count = 1.
REQ-027 Arithmetic SHALL wrap at ACC_W bits; no saturation or overflow flag.
REQ-028 clear SHALL have priority over all other events.
REQ-029 On clear, the block SHALL set state to ACC, set cnt, acc and out_count to 0, and drop out_valid the next cycle.
REQ-030 A beat offered in the same cycle as clear SHALL be discarded.
REQ-031 A result handshake in the same cycle as clear SHALL count as consumed.
REQ-032 in_valid pulses while in HOLD SHALL have no effect; the upstream holds pe_sum until in_ready.
REQ-033 A gap with in_valid = 0 mid-group SHALL hold cnt, acc and previous_sum unchanged.

Reset
REQ-034 While rst_n = 0, the block SHALL force state = ACC and cnt, len_q, acc, out_data and out_count to 0, asynchronously.
REQ-035 While rst_n = 0, out_valid SHALL be 0, in_ready SHALL be 1 and previous_sum SHALL be 0.
REQ-036 Reset asserted mid-group or in HOLD SHALL discard the partial or pending result.
REQ-037 After rst_n deasserts, the first accepted beat SHALL start a new group.

Verification
REQ-038 acc_len = 4, beats pe_sum = 10, 25, 40, 60 with a model adder -> previous_sum sequence 0, 10, 25, 40; out_valid 1 cycle after 4th beat; out_data = 60; out_count = 4.
REQ-039 acc_len = 0, beats 0xFFFFF then 5 -> two results, -1 then 5, each with out_count = 1 and previous_sum = 0 at each beat.
REQ-040 out_ready held 0 for 5 cycles in HOLD, in_valid held 1 -> in_ready = 0, out_data stable for all 5 cycles; out_ready = 1 gives one transfer, then the next group starts.
REQ-041 clear asserted on the 3rd beat of a length-4 group -> beat dropped, no out_valid; next beat sees previous_sum = 0.
REQ-042 acc_len changed from 4 to 2 mid-group -> current group still completes after 4 beats; the following group completes after 2.
REQ-043 rst_n pulsed low asynchronously during HOLD -> out_valid falls without a clock edge; all outputs 0 except in_ready = 1.
